// File: rtl/usb_midi_keycode_in_fifo.sv
// usb_midi_keycode_in_fifo
//   Avalon-MM slave input port. Buffers 8-bit keycode/MIDI bytes pushed by the
//   USB/MIDI front end in a DEPTH x 8 circular buffer and lets the CPU drain
//   them through a zero-latency register interface. Also provides status, a
//   sticky overflow flag and a level interrupt.
//
// Ports
//   clk, reset_n      : system clock, asynchronous active-low reset
//   address[1:0]      : register select (0 DATA, 1 STATUS, 2 IRQ_EN, 3 reserved)
//   chipselect        : slave select
//   read_n, write_n   : active-low read / write strobes
//   writedata[31:0]   : CPU write data
//   readdata[31:0]    : combinational read data, 0 when not selected
//   irq               : level interrupt (not-empty and/or overflow)
//   in_data[7:0]      : hardware byte
//   in_valid          : hardware byte present; the source never stalls
//   in_ready          : ~full, informational only
//
// Register map
//   0 DATA    (RO) [7:0] head byte (0 when empty), [8] ~empty; a read pops
//   1 STATUS      [CW-1:0] count, [8] empty, [9] full, [10] overflow
//                 write [10]=1 clears overflow, write [31]=1 flushes
//   2 IRQ_EN  (RW) [0] not-empty enable, [1] overflow enable
//   3 reserved, reads 0

module usb_midi_keycode_in_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;

  localparam int unsigned BIT_FLUSH   = 31;
  localparam int unsigned BIT_OVF_CLR = 10;

  // Storage and state
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    irq_en_q, irq_en_d;

  // Decoded strobes and flags
  logic empty;
  logic full;
  logic rd_data;
  logic wr_status;
  logic wr_irq_en;
  logic flush;
  logic ovf_clr;
  logic push;
  logic drop;
  logic pop;
  logic [7:0] head;

  // Status flags reflect the registered count at the start of the cycle
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Bus decode
  assign rd_data   = chipselect & ~read_n  & (address == ADDR_DATA);
  assign wr_status = chipselect & ~write_n & (address == ADDR_STATUS);
  assign wr_irq_en = chipselect & ~write_n & (address == ADDR_IRQ_EN);

  assign flush   = wr_status & writedata[BIT_FLUSH];
  assign ovf_clr = wr_status & writedata[BIT_OVF_CLR];

  // Flush wins over push/pop; a byte lost to a flush is not an overflow
  assign push = in_valid & ~full & ~flush;
  assign drop = in_valid &  full & ~flush;
  assign pop  = rd_data  & ~empty & ~flush;

  assign head = mem_q[rp_q];

  // Next-state logic
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;

    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A drop in the same cycle as a clear keeps the flag set
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    if (wr_irq_en) irq_en_d = writedata[1:0];
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 2'b00;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
    end
  end

  // Buffer array; contents need no reset because reads are masked while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data;
  end

  // Zero-latency read mux
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      unique case (address)
        ADDR_DATA: begin
          readdata[8] = ~empty;
          if (!empty) readdata[7:0] = head;
        end
        ADDR_STATUS: begin
          readdata[CW-1:0] = count_q;
          // OR so that a 9-bit count at DEPTH=256 still shows its MSB
          readdata[8]      = readdata[8] | empty;
          readdata[9]      = full;
          readdata[10]     = overflow_q;
        end
        ADDR_IRQ_EN: begin
          readdata[1:0] = irq_en_q;
        end
        default: readdata = '0;
      endcase
    end
  end

  assign irq      = (irq_en_q[0] & ~empty) | (irq_en_q[1] & overflow_q);
  assign in_ready = ~full;

  // Write-data bits with no function
  logic unused_writedata;
  assign unused_writedata = ^{writedata[30:11], writedata[9:2]};

endmodule

// File: doc/usb_midi_keycode_in_fifo.md
# usb_midi_keycode_in_fifo

Avalon-MM slave input port that buffers 8-bit keycode/MIDI bytes arriving from hardware (USB/MIDI front end) and lets the Nios CPU drain them, with status, sticky overflow and a level interrupt. It is the CPU-bound counterpart of the CPU-written keycode output port. The block sits on the same Avalon bus and presents zero-latency reads with no waitrequest.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256
- CW, $clog2(DEPTH)+1, width of the occupancy count (5 for DEPTH=16)

- clk  in  1  system clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe; each asserted cycle is one read
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data; zero latency
- irq  out  1  level interrupt to the CPU
- in_data  in  8  hardware byte
- in_valid  in  1  byte present this cycle; the source does not stall
- in_ready  out  1  equals ~full; informational only

## Operation
- Storage: DEPTH×8 circular buffer with write pointer wp, read pointer rp (log2 DEPTH bits each, wrapping modulo DEPTH) and count (CW bits, 0..DEPTH).
- The empty and full flags are derived from count at the start of the cycle (count==0 and count==DEPTH respectively).
- Push: in_valid & ~full. The block writes mem[wp], then increments wp and count.
- Drop: in_valid & full. The byte is discarded and overflow is set; count is unchanged.
- Pop: chipselect & ~read_n & address==0 & ~empty. The block increments rp and decrements count.
- A read at address 0 while empty does not pop and returns 0.
- Push and pop in the same cycle (not full, not empty): both occur and count is unchanged.
- Full and a pop in the same cycle: the pop occurs and the push is dropped with overflow set, because full is evaluated at the start of the cycle.
- Empty and a read in the same cycle: there is no pop. The pushed byte becomes readable the next cycle.
- Flush: a write to address 1 with writedata[31]=1 resets wp, rp and count to 0. A flush takes priority over a push or pop in the same cycle. A push dropped by a flush does not set overflow.
- Register map (unlisted bits read 0; a write to a read-only register is ignored):
  - 0 DATA (read-only): [7:0]=mem[rp] when not empty, else 0. [8]=~empty.
  - 1 STATUS: [CW-1:0]=count, [8]=empty, [9]=full, [10]=overflow. Writing 1 to bit 10 clears overflow; writing 1 to bit 31 flushes. A clear and a drop in the same cycle leaves overflow set.
  - 2 IRQ_EN (read/write): [0]=not-empty enable, [1]=overflow enable. Written from writedata[1:0].
  - 3 reserved: reads 0, writes ignored.
- irq = (IRQ_EN[0] & ~empty) | (IRQ_EN[1] & overflow), computed combinationally from registered state.
- readdata is 0 whenever chipselect=0.

## Timing
- Reset (asynchronous, active-low) sets wp=rp=count=0, overflow=0 and IRQ_EN=0. In reset, in_ready=1, irq=0 and readdata=0.
- Reset asserted mid-operation discards all buffered data immediately. Memory contents are don't-care because reads mask them while empty.
- Push latency: a byte accepted at edge N is visible at DATA, and in count and empty, from cycle N+1. irq rises in cycle N+1 when not-empty is enabled.
- Pop: readdata shows the head combinationally in the read cycle. rp advances at the end of that cycle, so back-to-back reads return consecutive entries.
- in_ready drops the cycle after count reaches DEPTH. It rises the cycle after the first pop from full.
- Register writes take effect at the edge ending the write cycle.
- Pointer wrap after DEPTH-1 is seamless, and ordering is preserved across the wrap.

## Test plan
- Reset → STATUS reads 0x100, DATA reads 0, irq=0, in_ready=1.
- Push 0x90, 0x3C, 0x7F, then read DATA three times → 0x190, 0x13C, 0x17F. A fourth read → 0, and STATUS reads 0x100.
- Set IRQ_EN=1 and push one byte → irq=1 the next cycle. Read DATA → irq=0 the following cycle.
- Push 17 bytes 0x00..0x10 with DEPTH=16 → full=1, in_ready=0, overflow=1, and STATUS reads 0x610. Draining returns 0x00..0x0F; 0x10 is lost.
- Full FIFO with a push and a DATA read in the same cycle → count=15 and overflow=1. Write STATUS bit 10 → overflow=0. With IRQ_EN=2, irq follows overflow.
- Push 5 bytes, then write STATUS with bit 31 while in_valid=1 → count=0, empty=1, overflow=0. Then 40 push/pop pairs verify data order across pointer wrap.
